iis_adc_rx: RTL
===============

IIS_ADC_RX -- requirements
Module: iis_adc_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: captured bits per channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo frames buffered (power of 2, ≥2).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz), sole clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port bclk  input  1  WM8731 audio bit clock, asynchronous, sampled in clk domain.
REQ-006 SHALL have port adclrc  input  1  ADC left/right clock (low = left), asynchronous.
REQ-007 SHALL have port adcdat  input  1  ADC serial data, MSB first, asynchronous.
REQ-008 SHALL have port enable  input  1  capture enable.
REQ-009 SHALL have port out_valid  output  1  FIFO head frame available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head frame.
REQ-011 SHALL have port out_left  output  DATA_WIDTH  head-frame left sample.
REQ-012 SHALL have port out_right  output  DATA_WIDTH  head-frame right sample.
REQ-013 SHALL have port overflow  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-014 SHALL have port frame_err  output  1  sticky: an adclrc edge arrived before a word completed.
REQ-015 SHALL have port err_clr  input  1  single-cycle clear of overflow and frame_err.

Function
REQ-016 SHALL pass bclk, adclrc and adcdat through 2-flop synchronizers, then detect bclk rising edges with a third stage; all capture SHALL occur only in cycles with a detected bclk rising edge (a "tick").
REQ-017 SHALL sample adclrc on each tick and flag an lrc edge when it differs from its value at the previous tick.
REQ-018 SHALL implement FSM states SYNC, SKIP, SHIFT, HOLD; the FSM SHALL be held in SYNC while enable is low.
REQ-019 SYNC: on a tick with a falling lrc edge (left start) → SKIP; all other lrc edges are ignored.
REQ-020 SKIP: the next tick (I2S one-bclk delay) → SHIFT, with bit counter = 0.
REQ-021 SHIFT: each tick shifts adcdat into the word MSB-first; after DATA_WIDTH bits → HOLD, storing the word to the left or right register per the lrc level.
REQ-022 HOLD: ignores extra bits; on an lrc edge tick → SKIP.
REQ-023 An lrc edge tick in SHIFT SHALL discard the partial word, set frame_err, and → SKIP; if the discarded word was left, the following right word SHALL also be discarded.
REQ-024 Completing a right word preceded by a valid left word SHALL push {left,right} into the FIFO in the clk cycle after the last bit's tick.
REQ-025 A push while the FIFO is full and out_ready is low SHALL drop the new frame and set overflow; if the FIFO is full and out_ready is high in the same cycle, pop and push SHALL both succeed.
REQ-026 A pop SHALL occur when out_valid && out_ready; out_left/out_right SHALL show the head frame whenever out_valid is high and be held stable until popped.
REQ-027 Dropping enable SHALL abandon any partial frame without flagging an error; FIFO contents SHALL be retained.
REQ-028 err_clr SHALL take priority under a simultaneous set event (clears win that cycle).

Reset
REQ-029 On rst: FSM=SYNC, FIFO empty, out_valid=0, out_left=0, out_right=0, overflow=0, frame_err=0, and synchronizer stages=0; rst mid-frame SHALL discard all partial data.

Configuration
REQ-030 With IIS_RX_PEAK_EN defined: add outputs peak_left and peak_right (DATA_WIDTH-1 bits each, |sample| held as a maximum over pushed frames) and input peak_clr; |−2^(W-1)| SHALL saturate to 2^(W-1)−1; peak_clr and rst zero them; peak_clr with a simultaneous push loads that frame's magnitude.
REQ-031 Without IIS_RX_PEAK_EN: these ports and their logic SHALL be absent.

Structure
REQ-032 SHALL place the FSM state encoding and default DATA_WIDTH/FIFO_DEPTH constants in the shared package iis_pkg, reused by the DAC transmitter.
REQ-033 SHALL implement the frame buffer as sub-module iis_frame_fifo (synchronous, first-word-fall-through, full/empty flags).

Verification
REQ-034 Enable, bclk=clk/32, send L=16'h1234, R=16'hABCD → one frame with out_left=16'h1234 and out_right=16'hABCD; out_valid rises the cycle after the last R bit.
REQ-035 Hold out_ready=0 and send 5 frames → first 4 retained in order, overflow=1; err_clr → overflow=0.
REQ-036 FIFO full, out_ready=1 during the 5th push → no overflow; 5th frame readable after the pops.
REQ-037 lrc toggles after 8 left bits → frame_err=1, no frame pushed; next full frame captured correctly.
REQ-038 Start the stream mid-right-channel → nothing pushed until the first complete left+right pair.
REQ-039 With IIS_RX_PEAK_EN: L=16'h8000, R=16'hFFFF → peak_left=16'h7FFF, peak_right=16'h0001; peak_clr → both 0.

Source files
------------

// File: rtl/iis_pkg.sv
// Shared I2S definitions: FSM state encoding, channel select and default sizes,
// used by both the ADC receiver and the DAC transmitter.
package iis_pkg;

    localparam int IIS_DATA_WIDTH = 16;
    localparam int IIS_FIFO_DEPTH = 4;

    typedef logic [1:0] iis_state_t;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // adclrc low selects the left channel
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } iis_chan_t;

endpackage

// File: rtl/iis_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module iis_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iis_adc_rx.sv
// I2S receiver for the WM8731 ADC: oversamples bclk/adclrc/adcdat in the clk
// domain and buffers stereo frames. Define IIS_RX_PEAK_EN for peak meters.
module iis_adc_rx
    import iis_pkg::*;
#(
    parameter int DATA_WIDTH = IIS_DATA_WIDTH,
    parameter int FIFO_DEPTH = IIS_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    input  logic                  enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  err_clr
`ifdef IIS_RX_PEAK_EN
    ,
    input  logic                  peak_clr,
    output logic [DATA_WIDTH-2:0] peak_left,
    output logic [DATA_WIDTH-2:0] peak_right
`endif
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [2:0]              bclk_sync;
    logic [1:0]              lrc_sync;
    logic [1:0]              dat_sync;
    logic                    lrc;
    logic                    lrc_prev;
    logic                    tick;
    logic                    lrc_edge;
    iis_state_t              state;
    iis_chan_t               chan;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   next_word;
    logic [DATA_WIDTH-1:0]   left_word;
    logic                    left_ok;
    logic                    push_req;
    logic [2*DATA_WIDTH-1:0] push_frame;
    logic [2*DATA_WIDTH-1:0] head;
    logic                    full;
    logic                    empty;
    logic                    abort;
    logic                    drop;

    assign lrc       = lrc_sync[1];
    assign tick      = bclk_sync[1] && !bclk_sync[2];
    assign lrc_edge  = tick && (lrc != lrc_prev);
    assign next_word = {shift_reg[DATA_WIDTH-2:0], dat_sync[1]};
    assign abort     = enable && lrc_edge && (state == ST_SHIFT);
    assign drop      = push_req && full && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            dat_sync  <= '0;
            lrc_prev  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk};
            lrc_sync  <= {lrc_sync[0], adclrc};
            dat_sync  <= {dat_sync[0], adcdat};
            if (tick) begin
                lrc_prev <= lrc;
            end
        end
    end

    // Word assembly; a frame is queued only when a right word completes
    // directly after a left word that also completed cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SYNC;
            chan       <= CH_LEFT;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_word  <= '0;
            left_ok    <= 1'b0;
            push_req   <= 1'b0;
            push_frame <= '0;
        end else begin
            push_req <= 1'b0;
            if (!enable) begin
                state   <= ST_SYNC;
                left_ok <= 1'b0;
            end else if (tick) begin
                case (state)
                    ST_SYNC: begin
                        if (lrc_edge && !lrc) begin
                            state <= ST_SKIP;
                            chan  <= CH_LEFT;
                        end
                    end
                    ST_SKIP: begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                    ST_SHIFT: begin
                        if (lrc_edge) begin
                            state   <= ST_SKIP;
                            chan    <= iis_chan_t'(lrc);
                            left_ok <= 1'b0;
                        end else begin
                            shift_reg <= next_word;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= ST_HOLD;
                                if (chan == CH_LEFT) begin
                                    left_word <= next_word;
                                    left_ok   <= 1'b1;
                                end else begin
                                    left_ok <= 1'b0;
                                    if (left_ok) begin
                                        push_req   <= 1'b1;
                                        push_frame <= {left_word, next_word};
                                    end
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (lrc_edge) begin
                            state <= ST_SKIP;
                            chan  <= iis_chan_t'(lrc);
                        end
                    end
                    default: state <= ST_SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (abort) begin
                frame_err <= 1'b1;
            end
        end
    end

    iis_frame_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_frame),
        .pop       (out_ready),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = !empty;
    assign out_left  = out_valid ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out_right = out_valid ? head[DATA_WIDTH-1:0] : '0;

`ifdef IIS_RX_PEAK_EN
    logic                  push_ok;
    logic [DATA_WIDTH-2:0] mag_left;
    logic [DATA_WIDTH-2:0] mag_right;

    // Two's-complement magnitude; the most negative code saturates.
    function automatic logic [DATA_WIDTH-2:0] magnitude(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] neg;
        neg = -s;
        if (!s[DATA_WIDTH-1]) begin
            magnitude = s[DATA_WIDTH-2:0];
        end else if (neg[DATA_WIDTH-1]) begin
            magnitude = '1;
        end else begin
            magnitude = neg[DATA_WIDTH-2:0];
        end
    endfunction

    assign push_ok   = push_req && (!full || out_ready);
    assign mag_left  = magnitude(push_frame[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign mag_right = magnitude(push_frame[DATA_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (peak_clr) begin
            peak_left  <= push_ok ? mag_left : '0;
            peak_right <= push_ok ? mag_right : '0;
        end else if (push_ok) begin
            if (mag_left > peak_left) begin
                peak_left <= mag_left;
            end
            if (mag_right > peak_right) begin
                peak_right <= mag_right;
            end
        end
    end
`endif

endmodule
